// File: rtl/icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_fill_ctrl
// Description : Flush/fill controller for the instruction-cache memory block.
//               On a flush request it takes ownership of the block's write
//               port, reads one aligned line of MEMSIZE words from main memory
//               over a req/ready bus, and writes each word at index
//               0..MEMSIZE-1. When the line is complete it releases the block
//               and publishes the line tag and a valid bit for hit detection.
// Ports       :
//   clk, reset_n        - clock (rising edge), async active-low reset
//   flush_req           - start a line fill (sampled in IDLE only)
//   flush_base          - byte address of the line (low ADDRBITS+2 bits ignored)
//   invalidate          - clear line_valid (IDLE only)
//   mem_addr/mem_rd     - memory read request, held until mem_rdy
//   mem_data/mem_rdy    - memory read data and acknowledge
//   flush_mode          - controller owns the cache memory block
//   flush_addr/flush_in - word index and data written into the block
//   flush_we            - one-cycle write strobe per word
//   busy/done           - fill in progress / one-cycle completion pulse
//   line_valid/line_tag - hit-detection state of the last completed fill
// Revision    : 1.0 - initial release
// ============================================================================
module icache_fill_ctrl #(
  parameter  int DATABITS    = 32,
  parameter  int ADDRBITS    = 5,
  parameter  int MEMADDRBITS = 32,
  localparam int MEMSIZE     = 2**ADDRBITS,
  localparam int TAGBITS     = MEMADDRBITS - ADDRBITS - 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush_req,
  input  logic [MEMADDRBITS-1:0] flush_base,
  input  logic                   invalidate,
  output logic [MEMADDRBITS-1:0] mem_addr,
  output logic                   mem_rd,
  input  logic [DATABITS-1:0]    mem_data,
  input  logic                   mem_rdy,
  output logic                   flush_mode,
  output logic [ADDRBITS-1:0]    flush_addr,
  output logic [DATABITS-1:0]    flush_in,
  output logic                   flush_we,
  output logic                   busy,
  output logic                   done,
  output logic                   line_valid,
  output logic [TAGBITS-1:0]     line_tag
);

  localparam logic [ADDRBITS-1:0] c_last_word = ADDRBITS'(MEMSIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDRBITS-1:0]   r_cnt;
  logic [TAGBITS-1:0]    r_base_tag;
  logic [ADDRBITS-1:0]   r_flush_addr;
  logic [DATABITS-1:0]   r_flush_in;
  logic                  r_line_valid;
  logic [TAGBITS-1:0]    r_line_tag;

  // Byte-offset bits of the line base are discarded on purpose: the line is
  // always fetched from its aligned start.
  logic w_unused_base_bits;
  assign w_unused_base_bits = ^flush_base[ADDRBITS+1:0];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic and state-decoded outputs. Outputs are pure decodes of
  // the state register so an asynchronous reset drops them immediately.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    flush_mode   = 1'b0;
    mem_rd       = 1'b0;
    flush_we     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (flush_req) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        flush_mode = 1'b1;
        busy       = 1'b1;
        mem_rd     = 1'b1;
        if (mem_rdy) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        flush_mode = 1'b1;
        busy       = 1'b1;
        flush_we   = 1'b1;
        if (r_cnt == c_last_word) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_REQ;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: word counter, line base, write data and line status
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= '0;
      r_base_tag   <= '0;
      r_flush_addr <= '0;
      r_flush_in   <= '0;
      r_line_valid <= 1'b0;
      r_line_tag   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A request takes priority over invalidate; both clear line_valid.
          if (flush_req) begin
            r_base_tag   <= flush_base[MEMADDRBITS-1:ADDRBITS+2];
            r_cnt        <= '0;
            r_line_valid <= 1'b0;
          end else if (invalidate) begin
            r_line_valid <= 1'b0;
          end
        end
        S_REQ: begin
          if (mem_rdy) begin
            r_flush_in   <= mem_data;
            r_flush_addr <= r_cnt;
          end
        end
        S_WRITE: begin
          if (r_cnt != c_last_word) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_line_valid <= 1'b1;
          r_line_tag   <= r_base_tag;
        end
        default: begin
        end
      endcase
    end
  end

  // The base is line-aligned, so base + 4*cnt is a plain concatenation and
  // can never carry out of the line.
  assign mem_addr   = {r_base_tag, r_cnt, 2'b00};
  assign flush_addr = r_flush_addr;
  assign flush_in   = r_flush_in;
  assign line_valid = r_line_valid;
  assign line_tag   = r_line_tag;

endmodule
`default_nettype wire

// File: tb/tb_icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_fill_ctrl
// Description : Self-checking bench for icache_fill_ctrl. A memory responder
//               with randomized wait states and data answers the read bus;
//               a line-level model (aligned base, per-word data, expected
//               completion cycle, tag) is compared against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_fill_ctrl;

  localparam int DATABITS    = 32;
  localparam int ADDRBITS    = 5;
  localparam int MEMADDRBITS = 32;
  localparam int MEMSIZE     = 2**ADDRBITS;
  localparam int TAGBITS     = MEMADDRBITS - ADDRBITS - 2;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   flush_req;
  logic [MEMADDRBITS-1:0] flush_base;
  logic                   invalidate;
  logic [MEMADDRBITS-1:0] mem_addr;
  logic                   mem_rd;
  logic [DATABITS-1:0]    mem_data;
  logic                   mem_rdy;
  logic                   flush_mode;
  logic [ADDRBITS-1:0]    flush_addr;
  logic [DATABITS-1:0]    flush_in;
  logic                   flush_we;
  logic                   busy;
  logic                   done;
  logic                   line_valid;
  logic [TAGBITS-1:0]     line_tag;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  icache_fill_ctrl #(
    .DATABITS    (DATABITS),
    .ADDRBITS    (ADDRBITS),
    .MEMADDRBITS (MEMADDRBITS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush_req  (flush_req),
    .flush_base (flush_base),
    .invalidate (invalidate),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_rdy    (mem_rdy),
    .flush_mode (flush_mode),
    .flush_addr (flush_addr),
    .flush_in   (flush_in),
    .flush_we   (flush_we),
    .busy       (busy),
    .done       (done),
    .line_valid (line_valid),
    .line_tag   (line_tag)
  );

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One line fill. fixed_wait >= 0 gives that many stall cycles per word,
  // otherwise 0..3 at random. disturb injects a foreign request+invalidate
  // mid-fill; abort_word >= 0 pulses reset while that word is written.
  task automatic do_fill(input logic [31:0] base, input int fixed_wait, input bit disturb,
                         input bit inval_with_req, input int abort_word);
    logic [DATABITS-1:0]    data [MEMSIZE];
    int                     waits [MEMSIZE];
    logic [MEMADDRBITS-1:0] line_base;
    logic [TAGBITS-1:0]     exp_tag;
    int                     exp_done;
    int                     k;
    int                     kk;
    int                     waited;
    int                     cyc;
    int                     limit;
    bit                     finished;
    bit                     aborted;

    line_base = {base[MEMADDRBITS-1:ADDRBITS+2], {(ADDRBITS+2){1'b0}}};
    exp_tag   = base[MEMADDRBITS-1:ADDRBITS+2];
    exp_done  = 1;
    for (int i = 0; i < MEMSIZE; i++) begin
      data[i]   = $urandom;
      waits[i]  = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
      exp_done += waits[i] + 2;
    end

    // Request accepted at the next rising edge; cycle 1 is the first cycle after it.
    flush_base = base;
    flush_req  = 1'b1;
    invalidate = inval_with_req;
    mem_rdy    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush_req  = 1'b0;
    invalidate = 1'b0;
    flush_base = $urandom;

    k        = 0;
    waited   = 0;
    cyc      = 0;
    limit    = exp_done + 20;
    finished = 1'b0;
    aborted  = 1'b0;
    while (!finished && !aborted && cyc < limit) begin
      cyc++;
      kk = k % MEMSIZE;
      if (done === 1'b1) begin
        finished = 1'b1;
        chk("done_cycle", 64'(cyc), 64'(exp_done));
        chk("words_written", 64'(k), 64'(MEMSIZE));
        chk("done_busy", busy, 0);
        chk("done_flush_mode", flush_mode, 0);
        chk("done_mem_rd", mem_rd, 0);
        chk("done_flush_we", flush_we, 0);
        chk("done_line_valid", line_valid, 0);
      end else begin
        chk("fill_busy", busy, 1);
        chk("fill_flush_mode", flush_mode, 1);
        chk("fill_line_valid", line_valid, 0);
        chk("rd_xor_we", mem_rd ^ flush_we, 1);
        if (mem_rd === 1'b1) begin
          chk("mem_addr", mem_addr, line_base + 32'(4 * k));
          if (waited >= waits[kk]) begin
            mem_rdy  = 1'b1;
            mem_data = data[kk];
            waited   = 0;
          end else begin
            mem_rdy  = 1'b0;
            mem_data = $urandom;
            waited++;
          end
        end else begin
          chk("flush_addr", flush_addr, 64'(k));
          chk("flush_in", flush_in, data[kk]);
          // Stray acknowledges outside a read must be ignored.
          mem_rdy  = 1'($urandom_range(0, 1));
          mem_data = $urandom;
          if (k == abort_word) begin
            #2 reset_n = 1'b0;
            #1;
            chk("abort_flush_mode", flush_mode, 0);
            chk("abort_mem_rd", mem_rd, 0);
            chk("abort_busy", busy, 0);
            chk("abort_flush_we", flush_we, 0);
            chk("abort_line_valid", line_valid, 0);
            chk("abort_flush_addr", flush_addr, 0);
            chk("abort_line_tag", line_tag, 0);
            mem_rdy = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
            aborted = 1'b1;
          end
          k++;
        end
        if (!aborted) begin
          if (disturb && cyc == 7) begin
            flush_req  = 1'b1;
            flush_base = 32'h0000_8000;
            invalidate = 1'b1;
          end else begin
            flush_req  = 1'b0;
            invalidate = 1'b0;
          end
          @(negedge clk);
        end
      end
    end
    flush_req  = 1'b0;
    invalidate = 1'b0;
    mem_rdy    = 1'b0;

    if (!finished && !aborted) begin
      chk("fill_timeout", 0, 1);
    end
    if (finished) begin
      @(negedge clk);
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("post_flush_mode", flush_mode, 0);
      chk("post_line_valid", line_valid, 1);
      chk("post_line_tag", line_tag, exp_tag);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    flush_req  = 1'b0;
    flush_base = '0;
    invalidate = 1'b0;
    mem_data   = '0;
    mem_rdy    = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_flush_mode", flush_mode, 0);
    chk("rst_flush_addr", flush_addr, 0);
    chk("rst_flush_in", flush_in, 0);
    chk("rst_flush_we", flush_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_line_valid", line_valid, 0);
    chk("rst_line_tag", line_tag, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_mem_rd", mem_rd, 0);
    chk("idle_busy", busy, 0);

    // Zero-wait fill of the line at 0x1200..0x127C
    do_fill(32'h0000_1234, 0, 1'b0, 1'b0, -1);

    // Three stall cycles per word
    do_fill($urandom, 3, 1'b0, 1'b0, -1);

    // Foreign request and invalidate during a fill are ignored
    do_fill($urandom, -1, 1'b1, 1'b0, -1);

    // Invalidate in IDLE clears line_valid one cycle later
    invalidate = 1'b1;
    @(negedge clk);
    invalidate = 1'b0;
    chk("idle_invalidate", line_valid, 0);

    // Reset while word 10 is written, then a fresh fill from word 0
    do_fill($urandom, -1, 1'b0, 1'b0, 10);
    do_fill($urandom, -1, 1'b0, 1'b0, -1);

    // Request and invalidate together: request wins, valid low until done
    do_fill($urandom, -1, 1'b0, 1'b1, -1);

    // Valid line holds in IDLE without invalidate
    repeat (3) @(negedge clk);
    chk("idle_hold_valid", line_valid, 1);

    // A few more random lines back to back
    for (int n = 0; n < 3; n++) begin
      do_fill($urandom, -1, 1'b0, 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
